// File: rtl/gmii_arbi_pkg.sv
// Shared types and default timing constants for the two-source GMII TX arbiter.
package gmii_arbi_pkg;

    // Arbiter FSM: wait for a request, hand out the grant, forward the frame,
    // then hold the line idle for the inter-frame gap.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XMIT  = 2'd2,
        ST_IFG   = 2'd3
    } arbi_state_e;

    // Idle cycles forced between granted frames.
    localparam int unsigned IFG_CYC_DEF  = 12;
    // Longest forwarded frame in tx_en-high cycles: preamble + SFD + 1522 bytes.
    localparam int unsigned MAX_LEN_DEF  = 1530;
    // Cycles a granted source may take before it starts driving tx_en.
    localparam int unsigned START_TO_DEF = 64;

    // Width of the frame-length counter; must hold MAX_LEN.
    localparam int unsigned LEN_W = 11;
    // Width of the grant-timeout and IFG counters.
    localparam int unsigned TMR_W = 16;

endpackage

// File: rtl/gmii_tx_arbi.sv
// Two-source GMII transmit arbiter. Picks one requester, forwards its GMII
// enable/data to the shared TX path one cycle later, enforces the maximum
// frame length, a start timeout and the inter-frame gap, and counts frames
// that ended normally.
//
// Handshake: a source raises reqN and holds it until gntN is seen; while gntN
// is high it may start its frame on tx_enN, and the grant ends on the cycle
// after tx_enN falls (or earlier on truncation, timeout or link loss).
module gmii_tx_arbi
    import gmii_arbi_pkg::*;
#(
    parameter int unsigned IFG_CYC  = IFG_CYC_DEF,
    parameter int unsigned MAX_LEN  = MAX_LEN_DEF,
    parameter int unsigned START_TO = START_TO_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        link,
    input  logic        req0,
    input  logic        req1,
    output logic        gnt0,
    output logic        gnt1,
    input  logic        tx_en0,
    input  logic        tx_en1,
    input  logic [7:0]  txd0,
    input  logic [7:0]  txd1,
    output logic        gmii_tx_en,
    output logic [7:0]  gmii_txd,
    output logic        trunc_err,
    output logic        to_err,
    output logic [15:0] frame_cnt0,
    output logic [15:0] frame_cnt1
);

    localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(START_TO - 1);
    localparam logic [TMR_W-1:0] IFG_LAST = TMR_W'(IFG_CYC - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

    arbi_state_e      state_q, state_d;
    logic             sel_q, sel_d;     // selected source
    logic             last_q, last_d;   // source granted most recently
    logic [LEN_W-1:0] len_q, len_d;
    logic [TMR_W-1:0] to_cnt_q, to_cnt_d;
    logic [TMR_W-1:0] ifg_cnt_q, ifg_cnt_d;
    logic             out_en_q, out_en_d;
    logic [7:0]       out_d_q, out_d_d;
    logic             trunc_q, to_q;
    logic [15:0]      cnt0_q, cnt0_d;
    logic [15:0]      cnt1_q, cnt1_d;

    logic             ev_start, ev_done, ev_trunc, ev_tmo;
    logic             gnt_act;

    // Only the selected source is ever looked at.
    logic             tx_en_sel;
    logic [7:0]       txd_sel;
    assign tx_en_sel = sel_q ? tx_en1 : tx_en0;
    assign txd_sel   = sel_q ? txd1   : txd0;

    // State register and all datapath registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= 1'b0;
            last_q    <= 1'b1;
            len_q     <= '0;
            to_cnt_q  <= '0;
            ifg_cnt_q <= '0;
            out_en_q  <= 1'b0;
            out_d_q   <= 8'h00;
            trunc_q   <= 1'b0;
            to_q      <= 1'b0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            len_q     <= len_d;
            to_cnt_q  <= to_cnt_d;
            ifg_cnt_q <= ifg_cnt_d;
            out_en_q  <= out_en_d;
            out_d_q   <= out_d_d;
            trunc_q   <= ev_trunc;
            to_q      <= ev_tmo;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
        end
    end

    // Next state, source selection and the frame events that drive counters.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        last_d   = last_q;
        ev_start = 1'b0;
        ev_done  = 1'b0;
        ev_trunc = 1'b0;
        ev_tmo   = 1'b0;
        if (!link) begin
            // Losing the link abandons any frame and parks in the gap state.
            state_d = ST_IFG;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        state_d = ST_GRANT;
                        sel_d   = (req0 && req1) ? ~last_q : req1;
                        last_d  = sel_d;
                    end
                end
                ST_GRANT: begin
                    if (tx_en_sel) begin
                        state_d  = ST_XMIT;
                        ev_start = 1'b1;
                    end else if (to_cnt_q == TO_LAST) begin
                        state_d = ST_IFG;
                        ev_tmo  = 1'b1;
                    end
                end
                ST_XMIT: begin
                    if (!tx_en_sel) begin
                        state_d = ST_IFG;
                        ev_done = 1'b1;
                    end else if (len_q == LEN_MAX) begin
                        state_d  = ST_IFG;
                        ev_trunc = 1'b1;
                    end
                end
                ST_IFG: begin
                    if (ifg_cnt_q == IFG_LAST) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Grant decode, registered GMII forwarding and counter next values.
    always_comb begin
        gnt_act = (state_q == ST_GRANT) || (state_q == ST_XMIT);
        gnt0    = gnt_act && !sel_q;
        gnt1    = gnt_act && sel_q;

        // Entering or staying in XMIT already implies the source's tx_en is high.
        out_en_d = (state_d == ST_XMIT);
        out_d_d  = out_en_d ? txd_sel : 8'h00;

        if (ev_start) begin
            len_d = LEN_W'(1);
        end else if ((state_q == ST_XMIT) && (state_d == ST_XMIT)) begin
            len_d = len_q + 1'b1;
        end else begin
            len_d = '0;
        end

        to_cnt_d  = ((state_q == ST_GRANT) && (state_d == ST_GRANT)) ? to_cnt_q + 1'b1 : '0;
        // While the link is down the gap restarts, so it is timed from link-up.
        ifg_cnt_d = ((state_q == ST_IFG) && (state_d == ST_IFG) && link) ? ifg_cnt_q + 1'b1 : '0;

        cnt0_d = (ev_done && !sel_q) ? cnt0_q + 1'b1 : cnt0_q;
        cnt1_d = (ev_done && sel_q)  ? cnt1_q + 1'b1 : cnt1_q;

        gmii_tx_en = out_en_q;
        gmii_txd   = out_d_q;
        trunc_err  = trunc_q;
        to_err     = to_q;
        frame_cnt0 = cnt0_q;
        frame_cnt1 = cnt1_q;
    end

endmodule

// File: tb/tb_gmii_tx_arbi.sv
// Directed bench for gmii_tx_arbi: every forwarded byte is queued with the
// cycle it must appear on gmii_txd, and a negedge monitor pops and compares.
module tb_gmii_tx_arbi;

    localparam int IFG  = 12;
    localparam int MAXL = 1530;
    localparam int STO  = 64;

    logic        clk;
    logic        rst_n;
    logic        link;
    logic        req0, req1;
    logic        gnt0, gnt1;
    logic        tx_en0, tx_en1;
    logic [7:0]  txd0, txd1;
    logic        gmii_tx_en;
    logic [7:0]  gmii_txd;
    logic        trunc_err, to_err;
    logic [15:0] frame_cnt0, frame_cnt1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Scoreboard entries: {cycle the byte must appear [23:0], byte}.
    logic [31:0] exp_q[$];
    logic [31:0] exp_v, got_v;

    bit mon_on = 0;
    bit noise = 0;
    int exp_cnt0 = 0, exp_cnt1 = 0;
    int hi_run = 0, last_hi_len = 0, fall_cyc = 0, last_gap = 0;
    bit prev_en = 0;
    int trunc_seen = 0, to_seen = 0;

    gmii_tx_arbi #(
        .IFG_CYC  (IFG),
        .MAX_LEN  (MAXL),
        .START_TO (STO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .link       (link),
        .req0       (req0),
        .req1       (req1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .tx_en0     (tx_en0),
        .tx_en1     (tx_en1),
        .txd0       (txd0),
        .txd1       (txd1),
        .gmii_tx_en (gmii_tx_en),
        .gmii_txd   (gmii_txd),
        .trunc_err  (trunc_err),
        .to_err     (to_err),
        .frame_cnt0 (frame_cnt0),
        .frame_cnt1 (frame_cnt1)
    );

    // Clock and cycle stamp.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Monitor: scoreboard pop, idle data, one-hot grant, frame length and gap.
    always @(negedge clk) begin
        if (mon_on) begin
            checks++;
            if (gnt0 === 1'b1 && gnt1 === 1'b1) begin
                errors++;
                $display("FAIL gnt_onehot: cycle %0d gnt0=%b gnt1=%b required at most one high", cyc, gnt0, gnt1);
            end
            checks++;
            if (gmii_tx_en === 1'b1) begin
                hi_run++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected: cycle %0d gmii_txd=%h required gmii_tx_en=0", cyc, gmii_txd);
                end else begin
                    exp_v = exp_q.pop_front();
                    got_v = {cyc[23:0], gmii_txd};
                    if (got_v !== exp_v) begin
                        errors++;
                        $display("FAIL out_data: got cycle %0d byte %h required cycle %0d byte %h",
                                 got_v[31:8], got_v[7:0], exp_v[31:8], exp_v[7:0]);
                    end
                end
                if (!prev_en) last_gap = cyc - fall_cyc;
            end else begin
                if (gmii_txd !== 8'h00) begin
                    errors++;
                    $display("FAIL idle_txd: cycle %0d gmii_tx_en=%b gmii_txd=%h required 00", cyc, gmii_tx_en, gmii_txd);
                end
                if (prev_en) begin
                    last_hi_len = hi_run;
                    hi_run = 0;
                    fall_cyc = cyc;
                end
            end
            prev_en = (gmii_tx_en === 1'b1);
            if (trunc_err === 1'b1) trunc_seen++;
            if (to_err === 1'b1) to_seen++;
        end
    end

    // Driver tasks.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_tx();
        tx_en0 = 1'b0;
        tx_en1 = 1'b0;
        txd0 = 8'h00;
        txd1 = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drive n bytes on source src; the first npush are expected one cycle later.
    task automatic drive_bytes(input int src, input int n, input int npush);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom_range(0, 255));
            if (src == 0) begin
                tx_en0 = 1'b1;
                txd0 = d;
                if (noise) begin
                    tx_en1 = 1'($urandom_range(0, 1));
                    txd1 = 8'($urandom_range(0, 255));
                end
            end else begin
                tx_en1 = 1'b1;
                txd1 = d;
                if (noise) begin
                    tx_en0 = 1'($urandom_range(0, 1));
                    txd0 = 8'($urandom_range(0, 255));
                end
            end
            if (i < npush) exp_q.push_back({24'(cyc + 1), d});
            tick();
        end
    endtask

    // Wait up to budget cycles for a grant; src 2 means either source.
    task automatic wait_gnt(input int src, input int budget, output bit ok, output int who);
        int n;
        ok = 1'b0;
        who = -1;
        n = 0;
        while (!ok && n <= budget) begin
            if (gnt0 === 1'b1 && (src == 0 || src == 2)) begin
                ok = 1'b1;
                who = 0;
            end else if (gnt1 === 1'b1 && (src == 1 || src == 2)) begin
                ok = 1'b1;
                who = 1;
            end else begin
                tick();
                n++;
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        link = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        clear_tx();
        tick();
        tick();
        exp_cnt0 = 0;
        exp_cnt1 = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        mon_on = 1'b1;
        checks++;
        if ({gnt0, gnt1, gmii_tx_en, trunc_err, to_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl: gnt0/gnt1/tx_en/trunc/to=%b required 00000",
                     {gnt0, gnt1, gmii_tx_en, trunc_err, to_err});
        end
        checks++;
        if (gmii_txd !== 8'h00) begin
            errors++;
            $display("FAIL reset_txd: got %h required 00", gmii_txd);
        end
        checks++;
        if (frame_cnt0 !== 16'd0 || frame_cnt1 !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d/%0d required 0/0", frame_cnt0, frame_cnt1);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        req0 = 1'b1;
        tick();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL single_gnt_latency: gnt0=%b gnt1=%b required 1 0", gnt0, gnt1);
        end
        req0 = 1'b0;
        noise = 1'b1;
        drive_bytes(0, 72, 72);
        noise = 1'b0;
        clear_tx();
        tick();
        checks++;
        if (gnt0 !== 1'b0) begin
            errors++;
            $display("FAIL single_gnt_release: gnt0=%b required 0", gnt0);
        end
        tick();
        exp_cnt0++;
        checks++;
        if (last_hi_len != 72) begin
            errors++;
            $display("FAIL single_len: got %0d required 72", last_hi_len);
        end
        checks++;
        if (frame_cnt0 !== 16'(exp_cnt0) || frame_cnt1 !== 16'(exp_cnt1)) begin
            errors++;
            $display("FAIL single_cnt: got %0d/%0d required %0d/%0d", frame_cnt0, frame_cnt1, exp_cnt0, exp_cnt1);
        end
        idle(IFG + 2);
    endtask

    task automatic test_alternate();
        bit ok;
        int who;
        apply_reset();
        rst_n = 1'b1;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int f = 0; f < 4; f++) begin
            wait_gnt(2, 40, ok, who);
            checks++;
            if (!ok || who != (f % 2)) begin
                errors++;
                $display("FAIL alt_order: frame %0d granted src %0d required %0d", f, who, f % 2);
            end
            if (!ok) return;
            if (who == 0) req0 = 1'b0; else req1 = 1'b0;
            drive_bytes(who, 64, 64);
            clear_tx();
            if (f < 2) begin
                if (who == 0) req0 = 1'b1; else req1 = 1'b1;
            end
            if (who == 0) exp_cnt0++; else exp_cnt1++;
            tick();
            tick();
            checks++;
            if (last_hi_len != 64) begin
                errors++;
                $display("FAIL alt_len: frame %0d got %0d required 64", f, last_hi_len);
            end
            if (f > 0) begin
                checks++;
                if (last_gap != IFG + 2) begin
                    errors++;
                    $display("FAIL alt_gap: frame %0d got %0d required %0d", f, last_gap, IFG + 2);
                end
            end
        end
        idle(IFG + 2);
        checks++;
        if (frame_cnt0 !== 16'(exp_cnt0) || frame_cnt1 !== 16'(exp_cnt1) || exp_cnt0 != 2) begin
            errors++;
            $display("FAIL alt_cnt: got %0d/%0d required 2/2", frame_cnt0, frame_cnt1);
        end
    endtask

    task automatic test_trunc();
        bit ok;
        int who;
        int t0;
        req0 = 1'b1;
        wait_gnt(0, 30, ok, who);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL trunc_gnt: no gnt0 within 30 cycles, required grant");
            return;
        end
        req0 = 1'b0;
        t0 = trunc_seen;
        drive_bytes(0, MAXL + 1, MAXL);
        checks++;
        if (gnt0 !== 1'b0 || trunc_err !== 1'b1 || gmii_tx_en !== 1'b0) begin
            errors++;
            $display("FAIL trunc_cut: gnt0=%b trunc_err=%b gmii_tx_en=%b required 0 1 0", gnt0, trunc_err, gmii_tx_en);
        end
        drive_bytes(0, 1600 - (MAXL + 1), 0);
        clear_tx();
        tick();
        tick();
        checks++;
        if (last_hi_len != MAXL) begin
            errors++;
            $display("FAIL trunc_len: got %0d required %0d", last_hi_len, MAXL);
        end
        checks++;
        if (trunc_seen - t0 != 1) begin
            errors++;
            $display("FAIL trunc_pulses: got %0d required 1", trunc_seen - t0);
        end
        checks++;
        if (frame_cnt0 !== 16'(exp_cnt0)) begin
            errors++;
            $display("FAIL trunc_cnt: got %0d required %0d", frame_cnt0, exp_cnt0);
        end
        idle(IFG + 4);
    endtask

    task automatic test_timeout();
        bit ok;
        int who;
        int g, to_c, n, t0;
        t0 = to_seen;
        req0 = 1'b1;
        req1 = 1'b1;
        wait_gnt(2, 30, ok, who);
        checks++;
        if (!ok || who != 1) begin
            errors++;
            $display("FAIL to_first_gnt: granted src %0d required 1", who);
            return;
        end
        g = cyc;
        req1 = 1'b0;
        n = 0;
        while (to_err !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        to_c = cyc;
        checks++;
        if (to_err !== 1'b1 || to_c != g + STO) begin
            errors++;
            $display("FAIL to_latency: to_err=%b after %0d cycles required 1 after %0d", to_err, to_c - g, STO);
        end
        checks++;
        if (gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL to_gnt_drop: gnt1=%b required 0", gnt1);
        end
        wait_gnt(0, 30, ok, who);
        checks++;
        if (!ok || cyc != to_c + IFG + 1) begin
            errors++;
            $display("FAIL to_next_gnt: gnt0 after %0d cycles required %0d", cyc - to_c, IFG + 1);
        end
        req0 = 1'b0;
        drive_bytes(0, 8, 8);
        clear_tx();
        exp_cnt0++;
        idle(3);
        checks++;
        if (to_seen - t0 != 1) begin
            errors++;
            $display("FAIL to_pulses: got %0d required 1", to_seen - t0);
        end
        checks++;
        if (frame_cnt0 !== 16'(exp_cnt0) || frame_cnt1 !== 16'(exp_cnt1)) begin
            errors++;
            $display("FAIL to_cnt: got %0d/%0d required %0d/%0d", frame_cnt0, frame_cnt1, exp_cnt0, exp_cnt1);
        end
        idle(IFG + 4);
    endtask

    task automatic test_link();
        bit ok;
        int who;
        bit bad;
        req1 = 1'b1;
        wait_gnt(1, 30, ok, who);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL link_gnt: no gnt1 within 30 cycles, required grant");
            return;
        end
        req1 = 1'b0;
        drive_bytes(1, 20, 20);
        link = 1'b0;
        drive_bytes(1, 1, 0);
        checks++;
        if (gmii_tx_en !== 1'b0 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL link_drop: gmii_tx_en=%b gnt1=%b required 0 0", gmii_tx_en, gnt1);
        end
        clear_tx();
        req0 = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (gnt0 !== 1'b0 || gnt1 !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL link_no_grant: grant seen while link=0, required none");
        end
        link = 1'b1;
        wait_gnt(0, 40, ok, who);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL link_resume: no gnt0 within 40 cycles after link up, required grant");
            return;
        end
        req0 = 1'b0;
        drive_bytes(0, 16, 16);
        clear_tx();
        exp_cnt0++;
        idle(3);
        checks++;
        if (frame_cnt0 !== 16'(exp_cnt0) || frame_cnt1 !== 16'(exp_cnt1)) begin
            errors++;
            $display("FAIL link_cnt: got %0d/%0d required %0d/%0d", frame_cnt0, frame_cnt1, exp_cnt0, exp_cnt1);
        end
        idle(IFG + 4);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int who;
        req0 = 1'b1;
        wait_gnt(0, 30, ok, who);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rmid_gnt: no gnt0 within 30 cycles, required grant");
            return;
        end
        req0 = 1'b0;
        drive_bytes(0, 10, 10);
        rst_n = 1'b0;
        drive_bytes(0, 1, 0);
        checks++;
        if ({gnt0, gnt1, gmii_tx_en, trunc_err, to_err} !== 5'b0 || gmii_txd !== 8'h00) begin
            errors++;
            $display("FAIL rmid_outputs: ctl=%b txd=%h required 00000 00",
                     {gnt0, gnt1, gmii_tx_en, trunc_err, to_err}, gmii_txd);
        end
        checks++;
        if (frame_cnt0 !== 16'd0 || frame_cnt1 !== 16'd0) begin
            errors++;
            $display("FAIL rmid_cnt_clear: got %0d/%0d required 0/0", frame_cnt0, frame_cnt1);
        end
        clear_tx();
        rst_n = 1'b1;
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        tick();
        req1 = 1'b1;
        tick();
        checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            errors++;
            $display("FAIL rmid_first_gnt: gnt0=%b gnt1=%b required 0 1", gnt0, gnt1);
        end
        req1 = 1'b0;
        drive_bytes(1, 8, 8);
        clear_tx();
        exp_cnt1++;
        idle(3);
        checks++;
        if (frame_cnt0 !== 16'(exp_cnt0) || frame_cnt1 !== 16'(exp_cnt1)) begin
            errors++;
            $display("FAIL rmid_cnt: got %0d/%0d required %0d/%0d", frame_cnt0, frame_cnt1, exp_cnt0, exp_cnt1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_trunc();
        test_timeout();
        test_link();
        test_reset_mid();
        idle(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d bytes never appeared, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
